omok_board_engine: RTL

//  Parametrised board engine for the OMOK game: stores stones and colours, accepts put/undo

---
 rtl/omok_pkg.sv | 46 ++++
 rtl/omok_board_engine_if.sv | 36 +++
 rtl/omok_move_stack.sv | 56 +++++
 rtl/omok_board_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/omok_pkg.sv
`default_nettype none
// ============================================================
// Package : omok_pkg
// Brief   : Shared types, colours, direction table and index helpers
// Rev     : 1.0
// ============================================================
package omok_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_CHECK = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    // Directions 0..3: horizontal, vertical, main diagonal, anti-diagonal
    function automatic logic signed [1:0] dir_drow(input logic [1:0] dir);
        return (dir == 2'd0) ? 2'sd0 : 2'sd1;
    endfunction

    function automatic logic signed [1:0] dir_dcol(input logic [1:0] dir);
        case (dir)
            2'd0:    return 2'sd1;
            2'd1:    return 2'sd0;
            2'd2:    return 2'sd1;
            default: return -2'sd1;
        endcase
    endfunction

    function automatic int idx_row(input int idx, input int n);
        return idx / n;
    endfunction

    function automatic int idx_col(input int idx, input int n);
        return idx % n;
    endfunction

    function automatic int rc_idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/omok_board_engine_if.sv
`default_nettype none
// ============================================================
// Interface : omok_board_engine_if
// Brief     : Cursor/button requests in, board view and status out
// Rev       : 1.0
// ============================================================
interface omok_board_engine_if #(
    parameter int BOARD_N    = 10,
    parameter int HIST_DEPTH = 100
);
    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int POS_W  = $clog2(CELLS);
    localparam int HCNT_W = $clog2(HIST_DEPTH + 1);

    logic [POS_W-1:0]  cur_pos;
    logic              put;
    logic              undo;
    logic [CELLS-1:0]  board_state;
    logic [CELLS-1:0]  turn_map;
    logic              side_to_move;
    logic              busy;
    logic              game_over;
    logic              winner;
    logic [HCNT_W-1:0] hist_cnt;

    modport master (
        output cur_pos, put, undo,
        input  board_state, turn_map, side_to_move, busy, game_over, winner, hist_cnt
    );

    modport slave (
        input  cur_pos, put, undo,
        output board_state, turn_map, side_to_move, busy, game_over, winner, hist_cnt
    );
endinterface
`default_nettype wire

// File: rtl/omok_move_stack.sv
`default_nettype none
// ============================================================
// Module : omok_move_stack
// Brief  : Circular LIFO of cell indices; oldest entry lost when full
// Rev    : 1.0
// ============================================================
module omok_move_stack #(
    parameter int DEPTH  = 100,
    parameter int DATA_W = 7,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  w_wr_ptr_inc;
    logic [PTR_W-1:0]  w_top_ptr;
    logic [CNT_W-1:0]  r_cnt;

    assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_top_ptr    = (r_wr_ptr == '0) ? PTR_W'(DEPTH - 1) : r_wr_ptr - 1'b1;
    assign top_data     = r_mem[w_top_ptr];
    assign cnt          = r_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Count saturates while the write pointer keeps wrapping over old entries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (push) begin
            r_wr_ptr <= w_wr_ptr_inc;
            if (r_cnt != CNT_W'(DEPTH)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (pop && (r_cnt != '0)) begin
            r_wr_ptr <= w_top_ptr;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/omok_board_engine.sv
`default_nettype none
// ============================================================
// Module : omok_board_engine
// Brief  : OMOK board store, put/undo FSM and sequential win checker
// Rev    : 1.0
// ============================================================
module omok_board_engine
    import omok_pkg::*;
#(
    parameter int BOARD_N    = 10,
    parameter int WIN_LEN    = 5,
    parameter int HIST_DEPTH = 100,
    parameter int POS_W      = $clog2(BOARD_N * BOARD_N)
) (
    input  logic               clk,
    input  logic               rst,
    omok_board_engine_if.slave bus
);
    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int HCNT_W = $clog2(HIST_DEPTH + 1);
    localparam int RC_W   = $clog2(BOARD_N) + 2;
    localparam int STEP_W = $clog2(WIN_LEN + 1);
    localparam int CNT_W  = $clog2(2 * WIN_LEN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_put_prev;
    logic                   r_undo_prev;
    logic [CELLS-1:0]       r_board;
    logic [CELLS-1:0]       r_turn;
    logic                   r_side;
    logic                   r_game_over;
    logic                   r_winner;
    logic                   r_colour;
    logic [POS_W-1:0]       r_pos;
    logic signed [RC_W-1:0] r_org_row;
    logic signed [RC_W-1:0] r_org_col;
    logic signed [RC_W-1:0] r_cur_row;
    logic signed [RC_W-1:0] r_cur_col;
    logic [1:0]             r_dir;
    logic                   r_phase;
    logic [STEP_W-1:0]      r_steps;
    logic [CNT_W-1:0]       r_count;

    logic                   w_put_req;
    logic                   w_undo_req;
    logic                   w_pos_valid;
    logic [POS_W-1:0]       w_cur_cell;
    logic                   w_push;
    logic                   w_pop;
    logic [POS_W-1:0]       w_top;
    logic [HCNT_W-1:0]      w_hist_cnt;
    logic signed [RC_W-1:0] w_dr;
    logic signed [RC_W-1:0] w_dc;
    logic signed [RC_W-1:0] w_nrow;
    logic signed [RC_W-1:0] w_ncol;
    logic                   w_in_bounds;
    logic [POS_W-1:0]       w_nidx;
    logic                   w_match;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   w_phase_end;
    logic                   w_win;

    assign w_put_req   = bus.put  & ~r_put_prev;
    assign w_undo_req  = bus.undo & ~r_undo_prev;
    assign w_pos_valid = int'(bus.cur_pos) < CELLS;
    assign w_cur_cell  = w_pos_valid ? bus.cur_pos : '0;

    // Walker: the minus half of each direction steps against the table delta
    assign w_dr        = RC_W'(dir_drow(r_dir));
    assign w_dc        = RC_W'(dir_dcol(r_dir));
    assign w_nrow      = r_cur_row + (r_phase ? -w_dr : w_dr);
    assign w_ncol      = r_cur_col + (r_phase ? -w_dc : w_dc);
    assign w_in_bounds = (w_nrow >= 0) && (w_nrow < $signed(RC_W'(BOARD_N))) &&
                         (w_ncol >= 0) && (w_ncol < $signed(RC_W'(BOARD_N)));
    assign w_nidx      = w_in_bounds ? POS_W'(rc_idx(int'(w_nrow), int'(w_ncol), BOARD_N)) : '0;
    assign w_match     = w_in_bounds && r_board[w_nidx] && (r_turn[w_nidx] == r_colour);
    assign w_count_nxt = r_count + CNT_W'(w_match);
    assign w_phase_end = ~w_match || (r_steps == STEP_W'(WIN_LEN - 2));
    assign w_win       = w_match && (w_count_nxt >= CNT_W'(WIN_LEN));

    omok_move_stack #(
        .DEPTH  (HIST_DEPTH),
        .DATA_W (POS_W),
        .CNT_W  (HCNT_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_pos),
        .top_data  (w_top),
        .cnt       (w_hist_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_undo_req && (w_hist_cnt != '0)) begin
                    w_pop = 1'b1;
                end else if (w_put_req && w_pos_valid && !r_board[w_cur_cell]) begin
                    w_state_nxt = ST_PLACE;
                end
            end
            ST_PLACE: begin
                w_push      = 1'b1;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_win) begin
                    w_state_nxt = ST_WIN;
                end else if (w_phase_end && r_phase && (r_dir == 2'd3)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WIN: begin
                if (w_undo_req && (w_hist_cnt != '0)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_put_prev  <= 1'b1;
            r_undo_prev <= 1'b1;
            r_board     <= '0;
            r_turn      <= '0;
            r_side      <= BLACK;
            r_game_over <= 1'b0;
            r_winner    <= BLACK;
            r_colour    <= BLACK;
            r_pos       <= '0;
            r_org_row   <= '0;
            r_org_col   <= '0;
            r_cur_row   <= '0;
            r_cur_col   <= '0;
            r_dir       <= '0;
            r_phase     <= 1'b0;
            r_steps     <= '0;
            r_count     <= '0;
        end else begin
            r_put_prev  <= bus.put;
            r_undo_prev <= bus.undo;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_board[w_top] <= 1'b0;
                        r_side         <= ~r_side;
                    end else if (w_state_nxt == ST_PLACE) begin
                        r_pos <= bus.cur_pos;
                    end
                end
                ST_PLACE: begin
                    r_board[r_pos] <= 1'b1;
                    r_turn[r_pos]  <= r_side;
                    r_colour       <= r_side;
                    r_org_row      <= RC_W'(idx_row(int'(r_pos), BOARD_N));
                    r_org_col      <= RC_W'(idx_col(int'(r_pos), BOARD_N));
                    r_cur_row      <= RC_W'(idx_row(int'(r_pos), BOARD_N));
                    r_cur_col      <= RC_W'(idx_col(int'(r_pos), BOARD_N));
                    r_dir          <= 2'd0;
                    r_phase        <= 1'b0;
                    r_steps        <= '0;
                    r_count        <= CNT_W'(1);
                end
                ST_CHECK: begin
                    if (w_win) begin
                        r_game_over <= 1'b1;
                        r_winner    <= r_colour;
                    end else if (w_phase_end) begin
                        r_cur_row <= r_org_row;
                        r_cur_col <= r_org_col;
                        r_steps   <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_count <= w_count_nxt;
                        end else begin
                            r_phase <= 1'b0;
                            r_dir   <= r_dir + 2'd1;
                            r_count <= CNT_W'(1);
                            if (r_dir == 2'd3) begin
                                r_side <= ~r_side;
                            end
                        end
                    end else begin
                        r_cur_row <= w_nrow;
                        r_cur_col <= w_ncol;
                        r_steps   <= r_steps + 1'b1;
                        r_count   <= w_count_nxt;
                    end
                end
                ST_WIN: begin
                    if (w_pop) begin
                        r_board[w_top] <= 1'b0;
                        r_game_over    <= 1'b0;
                        r_side         <= r_turn[w_top];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.board_state  = r_board;
    assign bus.turn_map     = r_turn;
    assign bus.side_to_move = r_side;
    assign bus.busy         = (r_state == ST_PLACE) || (r_state == ST_CHECK);
    assign bus.game_over    = r_game_over;
    assign bus.winner       = r_winner;
    assign bus.hist_cnt     = w_hist_cnt;

endmodule
`default_nettype wire
